// File: rtl/hazard_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : hazard_sequencer
// Description : Pipeline hazard sequencer. Resolves load-use, branch-flush and
//               data-memory wait conditions into PC / IF-ID / ID-EX / EX-MEM
//               control, counts stalled cycles and flags over-long memory waits.
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_sequencer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ID_EX_memRead,
  input  logic [4:0]  ID_EX_rt,
  input  logic [4:0]  IF_ID_rs,
  input  logic [4:0]  IF_ID_rt,
  input  logic        branch_taken,
  input  logic        mem_req,
  input  logic        mem_ready,
  output logic        PC_write,
  output logic        IF_ID_write,
  output logic        IF_ID_flush,
  output logic        ID_EX_bubble,
  output logic        EX_M_hold,
  output logic [15:0] stall_cycles,
  output logic        mem_timeout
);

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_LU_STALL = 2'd1,
    ST_MEM_WAIT = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  wait_cnt_q, wait_cnt_d;
  logic [15:0] stall_cycles_q, stall_cycles_d;
  logic        mem_timeout_q, mem_timeout_d;

  logic ld_hz;
  logic mem_st;
  logic in_wait;

  assign ld_hz  = ID_EX_memRead && (ID_EX_rt != 5'd0) &&
                  ((ID_EX_rt == IF_ID_rs) || (ID_EX_rt == IF_ID_rt));
  assign mem_st = mem_req && !mem_ready;

  // A waiting cycle only counts while we are already parked in MEM_WAIT.
  assign in_wait = (state_q == ST_MEM_WAIT) && mem_st;

  // State, wait counter, stall counter and sticky timeout registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_RUN;
      wait_cnt_q     <= 8'd0;
      stall_cycles_q <= 16'd0;
      mem_timeout_q  <= 1'b0;
    end else begin
      state_q        <= state_d;
      wait_cnt_q     <= wait_cnt_d;
      stall_cycles_q <= stall_cycles_d;
      mem_timeout_q  <= mem_timeout_d;
    end
  end

  // Next state and control outputs; priority is memory > branch > load-use.
  // MEM_WAIT needs no special branch: once mem_st drops it follows RUN rules.
  always_comb begin
    state_d      = ST_RUN;
    PC_write     = 1'b1;
    IF_ID_write  = 1'b1;
    IF_ID_flush  = 1'b0;
    ID_EX_bubble = 1'b0;
    EX_M_hold    = 1'b0;
    if (mem_st) begin
      PC_write    = 1'b0;
      IF_ID_write = 1'b0;
      EX_M_hold   = 1'b1;
      state_d     = ST_MEM_WAIT;
    end else if (branch_taken) begin
      IF_ID_flush  = 1'b1;
      ID_EX_bubble = 1'b1;
    end else if (ld_hz && (state_q != ST_LU_STALL)) begin
      // Hazard is masked in LU_STALL so the stall never exceeds one cycle.
      PC_write     = 1'b0;
      IF_ID_write  = 1'b0;
      ID_EX_bubble = 1'b1;
      state_d      = ST_LU_STALL;
    end
    // Reset drops any freeze or bubble immediately, without waiting for clk.
    if (!rst_n) begin
      PC_write     = 1'b1;
      IF_ID_write  = 1'b1;
      IF_ID_flush  = 1'b0;
      ID_EX_bubble = 1'b0;
      EX_M_hold    = 1'b0;
    end
  end

  // Wait counter (saturating, cleared outside a wait), timeout and stall count.
  always_comb begin
    wait_cnt_d     = 8'd0;
    mem_timeout_d  = mem_timeout_q;
    stall_cycles_d = stall_cycles_q;
    if (in_wait) begin
      wait_cnt_d = (wait_cnt_q == 8'hFF) ? wait_cnt_q : wait_cnt_q + 8'd1;
      if (wait_cnt_q == 8'hFF) begin
        mem_timeout_d = 1'b1;
      end
    end
    if (!PC_write && (stall_cycles_q != 16'hFFFF)) begin
      stall_cycles_d = stall_cycles_q + 16'd1;
    end
  end

  assign stall_cycles = stall_cycles_q;
  assign mem_timeout  = mem_timeout_q;

endmodule
`default_nettype wire

// File: tb/tb_hazard_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_hazard_sequencer
// Description : Self-checking bench for hazard_sequencer: directed vector
//               table, hand-written multi-cycle sequences and a randomized run
//               against a rule-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hazard_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        ID_EX_memRead = 1'b0;
  logic [4:0]  ID_EX_rt = 5'd0;
  logic [4:0]  IF_ID_rs = 5'd0;
  logic [4:0]  IF_ID_rt = 5'd0;
  logic        branch_taken = 1'b0;
  logic        mem_req = 1'b0;
  logic        mem_ready = 1'b0;
  logic        PC_write, IF_ID_write, IF_ID_flush, ID_EX_bubble, EX_M_hold;
  logic [15:0] stall_cycles;
  logic        mem_timeout;

  // Control output bundle: {PC_write, IF_ID_write, IF_ID_flush, ID_EX_bubble, EX_M_hold}
  localparam logic [4:0] C_NORM = 5'b11000;
  localparam logic [4:0] C_LU   = 5'b00010;
  localparam logic [4:0] C_FL   = 5'b11110;
  localparam logic [4:0] C_FZ   = 5'b00001;

  typedef struct {
    logic       mr;
    logic [4:0] rt;
    logic [4:0] rs;
    logic [4:0] it;
    logic       br;
    logic       mq;
    logic       rdy;
    logic [4:0] exp;
  } vec_t;

  int total = 0;
  int bad   = 0;

  hazard_sequencer dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .ID_EX_memRead(ID_EX_memRead),
    .ID_EX_rt     (ID_EX_rt),
    .IF_ID_rs     (IF_ID_rs),
    .IF_ID_rt     (IF_ID_rt),
    .branch_taken (branch_taken),
    .mem_req      (mem_req),
    .mem_ready    (mem_ready),
    .PC_write     (PC_write),
    .IF_ID_write  (IF_ID_write),
    .IF_ID_flush  (IF_ID_flush),
    .ID_EX_bubble (ID_EX_bubble),
    .EX_M_hold    (EX_M_hold),
    .stall_cycles (stall_cycles),
    .mem_timeout  (mem_timeout)
  );

  always #5 clk = ~clk;

  function automatic logic [4:0] outs();
    return {PC_write, IF_ID_write, IF_ID_flush, ID_EX_bubble, EX_M_hold};
  endfunction

  task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic mr, input logic [4:0] rt, input logic [4:0] rs,
                              input logic [4:0] it, input logic br, input logic mq,
                              input logic rdy, input logic [4:0] exp);
    vec_t v;
    v.mr = mr; v.rt = rt; v.rs = rs; v.it = it;
    v.br = br; v.mq = mq; v.rdy = rdy; v.exp = exp;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    ID_EX_memRead = v.mr;
    ID_EX_rt      = v.rt;
    IF_ID_rs      = v.rs;
    IF_ID_rt      = v.it;
    branch_taken  = v.br;
    mem_req       = v.mq;
    mem_ready     = v.rdy;
  endtask

  // Drive one cycle, compare outputs on the falling edge, then cross the rising edge.
  task automatic apply(input vec_t v, input string nm);
    drive(v);
    @(negedge clk);
    check(nm, {11'd0, outs()}, {11'd0, v.exp});
    @(posedge clk);
    #1;
  endtask

  task automatic step(input vec_t v);
    drive(v);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    drive(mk(0, 0, 0, 0, 0, 0, 0, C_NORM));
    rst_n = 1'b0;
    #1;
    check("reset_outs", {11'd0, outs()}, {11'd0, C_NORM});
    check("reset_stall", stall_cycles, 16'd0);
    check("reset_timeout", {15'd0, mem_timeout}, 16'd0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  vec_t tbl[15];
  vec_t idle;

  // Reference model state, kept at the level of the rules rather than states.
  logic     m_prev_lu;
  int       m_run;
  int       m_stall;
  logic     m_to;

  initial begin
    idle = mk(0, 0, 0, 0, 0, 0, 0, C_NORM);
    //            mr rt  rs  it  br mq rdy exp
    tbl[0]  = mk(0, 0,  0,  0,  0, 0, 0, C_NORM);
    tbl[1]  = mk(1, 5,  5,  0,  0, 0, 0, C_LU);   // load-use on rs
    tbl[2]  = mk(1, 5,  5,  0,  0, 0, 0, C_NORM); // masked in LU_STALL
    tbl[3]  = mk(1, 0,  0,  0,  0, 0, 0, C_NORM); // r0 never stalls
    tbl[4]  = mk(1, 7,  0,  7,  0, 0, 0, C_LU);   // load-use on rt
    tbl[5]  = mk(1, 7,  0,  7,  1, 0, 0, C_FL);   // branch in LU_STALL
    tbl[6]  = mk(1, 3,  3,  0,  1, 0, 0, C_FL);   // branch beats load-use
    tbl[7]  = mk(1, 4,  4,  0,  1, 1, 0, C_FZ);   // memory beats everything
    tbl[8]  = mk(1, 4,  4,  0,  1, 1, 0, C_FZ);
    tbl[9]  = mk(0, 0,  0,  0,  1, 1, 1, C_FL);   // ready cycle advances with flush
    tbl[10] = mk(0, 0,  0,  0,  0, 1, 0, C_FZ);
    tbl[11] = mk(1, 9,  9,  0,  0, 0, 0, C_LU);   // load-use straight out of MEM_WAIT
    tbl[12] = mk(0, 0,  0,  0,  0, 1, 0, C_FZ);   // memory stall from LU_STALL
    tbl[13] = mk(0, 0,  0,  0,  0, 1, 1, C_NORM);
    tbl[14] = mk(0, 0,  0,  0,  0, 0, 0, C_NORM);

    #2;
    do_reset();

    // Directed vector table.
    for (int i = 0; i < 15; i++) begin
      apply(tbl[i], $sformatf("tbl[%0d]", i));
    end
    check("tbl_stall_cycles", stall_cycles, 16'd7);

    // Single load-use stall counts exactly one cycle.
    do_reset();
    apply(mk(1, 5, 5, 0, 0, 0, 0, C_LU), "lu_stall");
    apply(mk(1, 5, 5, 0, 0, 0, 0, C_NORM), "lu_release");
    check("lu_stall_cycles", stall_cycles, 16'd1);

    // Three-cycle memory wait, released in the ready cycle.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      apply(mk(0, 0, 0, 0, 0, 1, 0, C_FZ), $sformatf("memwait[%0d]", i));
    end
    apply(mk(0, 0, 0, 0, 0, 1, 1, C_NORM), "mem_ready_release");
    check("memwait_stall_cycles", stall_cycles, 16'd3);

    // Timeout boundary: sticky flag after the 257th consecutive waiting cycle.
    do_reset();
    for (int i = 0; i < 256; i++) begin
      step(mk(0, 0, 0, 0, 0, 1, 0, C_FZ));
    end
    check("timeout_before_limit", {15'd0, mem_timeout}, 16'd0);
    step(mk(0, 0, 0, 0, 0, 1, 0, C_FZ));
    check("timeout_at_limit", {15'd0, mem_timeout}, 16'd1);
    for (int i = 257; i < 300; i++) begin
      step(mk(0, 0, 0, 0, 0, 1, 0, C_FZ));
    end
    check("timeout_wait_continues", {11'd0, outs()}, {11'd0, C_FZ});
    apply(mk(0, 0, 0, 0, 0, 1, 1, C_NORM), "timeout_release");
    step(idle);
    check("timeout_sticky", {15'd0, mem_timeout}, 16'd1);
    check("timeout_stall_cycles", stall_cycles, 16'd300);
    do_reset();
    check("timeout_cleared", {15'd0, mem_timeout}, 16'd0);

    // Reset asserted mid-wait drops the freeze without a clock edge.
    do_reset();
    apply(mk(0, 0, 0, 0, 0, 1, 0, C_FZ), "pre_rst_wait0");
    apply(mk(0, 0, 0, 0, 0, 1, 0, C_FZ), "pre_rst_wait1");
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_midwait_hold", {15'd0, EX_M_hold}, 16'd0);
    check("rst_midwait_pc", {15'd0, PC_write}, 16'd1);
    check("rst_midwait_stall", stall_cycles, 16'd0);
    drive(idle);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    apply(mk(1, 5, 0, 5, 0, 0, 0, C_LU), "post_rst_run");
    apply(idle, "post_rst_normal");

    // Randomized run against the rule-level model.
    do_reset();
    m_prev_lu = 1'b0;
    m_run     = 0;
    m_stall   = 0;
    m_to      = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      vec_t v;
      logic mst, ld;
      v.mr  = 1'($urandom_range(0, 1));
      v.rt  = 5'($urandom_range(0, 3));
      v.rs  = 5'($urandom_range(0, 3));
      v.it  = 5'($urandom_range(0, 3));
      v.br  = ($urandom_range(0, 3) == 0);
      v.mq  = ($urandom_range(0, 2) == 0);
      v.rdy = 1'($urandom_range(0, 1));
      mst = v.mq && !v.rdy;
      ld  = v.mr && (v.rt != 0) && ((v.rt == v.rs) || (v.rt == v.it));
      if (mst)                   v.exp = C_FZ;
      else if (v.br)             v.exp = C_FL;
      else if (ld && !m_prev_lu) v.exp = C_LU;
      else                       v.exp = C_NORM;
      drive(v);
      @(negedge clk);
      check("rand_outs", {11'd0, outs()}, {11'd0, v.exp});
      @(posedge clk);
      #1;
      m_prev_lu = (v.exp == C_LU);
      m_run     = mst ? m_run + 1 : 0;
      if (m_run >= 257) m_to = 1'b1;
      if (!v.exp[4] && m_stall < 65535) m_stall++;
      check("rand_stall_cycles", stall_cycles, 16'(m_stall));
      check("rand_timeout", {15'd0, mem_timeout}, {15'd0, m_to});
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
